apb_soc_demux: RTL and testbench
================================

Name: apb_soc_demux

Overview:
Parametrised APB demultiplexer between the SoC APB master and NUM_SLAVES peripheral slaves (FLL, HyperBus cfg, adv timer, padframe, GPIO, SoC ctrl, uDMA by default). It replaces the fixed constant address map with a parameter-driven rule table and registered decode. It adds a PSLVERR response for unmapped addresses, a per-transfer timeout watchdog, and sticky error capture.

Parameters:
NUM_SLAVES, 7, number of downstream APB slaves (1..32)
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width (multiple of 8)
START_ADDR, {1A10_0000,1A10_1000,1A10_3000,1A10_4000,1A10_5000,1A10_6000,1A20_0000}, packed NUM_SLAVES x ADDR_WIDTH rule starts (inclusive)
END_ADDR, {1A10_1000,1A10_2000,1A10_4000,1A10_5000,1A10_6000,1A10_7000,1A22_2000}, packed rule ends (exclusive)
TIMEOUT_CYCLES, 256, max ACCESS cycles before abort; 0 disables watchdog

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
paddr_i  in  ADDR_WIDTH  upstream address
pwdata_i  in  DATA_WIDTH  upstream write data
pwrite_i  in  1  upstream write
pstrb_i  in  DATA_WIDTH/8  upstream byte strobes
psel_i  in  1  upstream select
penable_i  in  1  upstream enable
prdata_o  out  DATA_WIDTH  upstream read data
pready_o  out  1  upstream ready
pslverr_o  out  1  upstream error
paddr_o  out  ADDR_WIDTH  shared downstream address (registered)
pwdata_o  out  DATA_WIDTH  shared downstream write data (registered)
pwrite_o  out  1  shared downstream write (registered)
pstrb_o  out  DATA_WIDTH/8  shared downstream strobes (registered)
psel_o  out  NUM_SLAVES  one-hot downstream select
penable_o  out  1  shared downstream enable
prdata_i  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave k at [k*DATA_WIDTH +: DATA_WIDTH]
pready_i  in  NUM_SLAVES  per-slave ready
pslverr_i  in  NUM_SLAVES  per-slave error
err_clr_i  in  1  clear sticky error status
err_cnt_o  out  8  saturating count of decode and timeout errors
err_addr_o  out  ADDR_WIDTH  address of the most recent error
err_timeout_o  out  1  most recent error was a timeout (0 = decode miss)

Behaviour:
- Reset drives every output and register to 0. Reset asserted mid-transfer aborts the transfer immediately, and the FSM returns to IDLE.
- Decode: a hit on rule k means START_ADDR[k] <= paddr_i < END_ADDR[k]. On overlapping rules the lowest index wins. A rule with start >= end never matches.
- FSM states are IDLE, DSETUP, DACCESS, RESP, ERR.
- IDLE: on psel_i=1 and penable_i=0, latch paddr/pwdata/pwrite/pstrb into the *_o registers.
  - On a hit, latch index k and go to DSETUP.
  - On a miss, go to ERR.
- DSETUP (1 cycle): psel_o[k]=1, penable_o=0. Go to DACCESS.
- DACCESS: psel_o[k]=1, penable_o=1, and the timeout counter increments.
  - pready_i[k]=1: latch prdata_i slice k and pslverr_i[k], then go to RESP.
  - Watchdog enabled, counter = TIMEOUT_CYCLES-1, and pready_i[k]=0: abort with psel_o=0, latch prdata=0 and pslverr=1, log a timeout error, and go to RESP.
  - pready_i[k] and timeout in the same cycle: pready_i wins and no error is logged.
- RESP: pready_o=1 with the latched prdata_o/pslverr_o, qualified by penable_i=1. If penable_i=0, hold RESP until penable_i=1. Return to IDLE.
- ERR: log a decode error, then drive pready_o=1, pslverr_o=1, prdata_o=0 while penable_i=1, and return to IDLE.
- pready_o is 1 only in the RESP and ERR states. prdata_o is 0 whenever pready_o=0. psel_o stays one-hot or zero.
- Hit latency: upstream SETUP at cycle T, downstream SETUP at T+1, downstream ACCESS at T+2. If pready_i is high at T+2, pready_o is high at T+3. Minimum 4 upstream cycles per transfer.
- Upstream psel_i dropping before pready_o (protocol violation):
  - an active downstream transfer still completes;
  - its response is discarded and pready_o stays 0;
  - the FSM returns to IDLE.
- Error log, on each error:
  - err_cnt_o increments, saturating at 255;
  - err_addr_o and err_timeout_o update.
- err_clr_i=1 zeroes all three status outputs. If err_clr_i and a new error occur in the same cycle, the status becomes err_cnt_o=1 with the new error's addr/type.

Test Plan:
- Write 0xDEADBEEF to 0x1A10_5004 with slave 4 ready at first ACCESS -> psel_o=0b0010000 at T+1..T+2, penable_o at T+2, paddr_o=0x1A10_5004, pready_o at T+3, pslverr_o=0.
- Read 0x1A21_FFFC with slave 6 holding pready_i low 3 cycles, prdata=0x12345678 -> pready_o at T+6, prdata_o=0x12345678.
- Read unmapped 0x1A10_2000 -> no psel_o asserted, pready_o=1 with pslverr_o=1 and prdata_o=0 at T+1, err_cnt_o=1, err_addr_o=0x1A10_2000, err_timeout_o=0.
- Slave 0 never ready, TIMEOUT_CYCLES=256 -> psel_o drops after 256 ACCESS cycles, pslverr_o=1, err_timeout_o=1.
- 300 decode misses -> err_cnt_o saturates at 255. err_clr_i coincident with a new miss -> err_cnt_o=1.
- rst_ni pulsed low during DACCESS -> psel_o, penable_o and pready_o go to 0 immediately. A following transfer to 0x1A10_0000 completes normally.

Source files
------------

// File: rtl/apb_soc_demux.sv
// APB demultiplexer from the SoC APB master to NUM_SLAVES peripherals.
// The address map comes from a rule table, and the decode result is registered.
module apb_soc_demux #(
   parameter int unsigned                         NUM_SLAVES     = 7,
   parameter int unsigned                         ADDR_WIDTH     = 32,
   parameter int unsigned                         DATA_WIDTH     = 32,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]    START_ADDR     = {32'h1A20_0000, 32'h1A10_6000,
                                                                   32'h1A10_5000, 32'h1A10_4000,
                                                                   32'h1A10_3000, 32'h1A10_1000,
                                                                   32'h1A10_0000},
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]    END_ADDR       = {32'h1A22_2000, 32'h1A10_7000,
                                                                   32'h1A10_6000, 32'h1A10_5000,
                                                                   32'h1A10_4000, 32'h1A10_2000,
                                                                   32'h1A10_1000},
   parameter int unsigned                         TIMEOUT_CYCLES = 256
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [ADDR_WIDTH-1:0]          paddr_i,
   input  logic [DATA_WIDTH-1:0]          pwdata_i,
   input  logic                           pwrite_i,
   input  logic [DATA_WIDTH/8-1:0]        pstrb_i,
   input  logic                           psel_i,
   input  logic                           penable_i,
   output logic [DATA_WIDTH-1:0]          prdata_o,
   output logic                           pready_o,
   output logic                           pslverr_o,
   output logic [ADDR_WIDTH-1:0]          paddr_o,
   output logic [DATA_WIDTH-1:0]          pwdata_o,
   output logic                           pwrite_o,
   output logic [DATA_WIDTH/8-1:0]        pstrb_o,
   output logic [NUM_SLAVES-1:0]          psel_o,
   output logic                           penable_o,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata_i,
   input  logic [NUM_SLAVES-1:0]          pready_i,
   input  logic [NUM_SLAVES-1:0]          pslverr_i,
   input  logic                           err_clr_i,
   output logic [7:0]                     err_cnt_o,
   output logic [ADDR_WIDTH-1:0]          err_addr_o,
   output logic                           err_timeout_o
);

   localparam int unsigned IW    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int unsigned TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [2:0] {IDLE, DSETUP, DACCESS, RESP, ERR} state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           idx_q;
   logic [TW-1:0]           to_cnt_q;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    rerr_q, rerr_d;
   logic [7:0]              err_cnt_q;
   logic [ADDR_WIDTH-1:0]   err_addr_q;
   logic                    err_to_q;

   logic                    dec_hit;
   logic [IW-1:0]           dec_idx;
   logic [NUM_SLAVES-1:0]   sel_oh;
   logic                    sel_ready, sel_err, timeout_hit;
   logic [DATA_WIDTH-1:0]   sel_rdata;
   logic                    latch_req, latch_resp;
   logic                    err_evt, err_evt_to;
   logic [ADDR_WIDTH-1:0]   err_evt_addr;

   // Lowest matching index wins, and an empty rule (start >= end) never matches.
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
         if (!dec_hit &&
             paddr_i >= START_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH] &&
             paddr_i <  END_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
            dec_hit = 1'b1;
            dec_idx = IW'(k);
         end
      end
   end

   always_comb begin
      sel_oh    = '0;
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
         if (idx_q == IW'(k)) begin
            sel_oh[k] = 1'b1;
            sel_ready = pready_i[k];
            sel_err   = pslverr_i[k];
            sel_rdata = prdata_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign timeout_hit = WD_EN && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d      = state_q;
      latch_req    = 1'b0;
      latch_resp   = 1'b0;
      rdata_d      = sel_rdata;
      rerr_d       = sel_err;
      err_evt      = 1'b0;
      err_evt_to   = 1'b0;
      err_evt_addr = paddr_i;
      pready_o     = 1'b0;
      pslverr_o    = 1'b0;
      prdata_o     = '0;
      case (state_q)
         IDLE: begin
            if (psel_i && !penable_i) begin
               latch_req = 1'b1;
               if (dec_hit) begin
                  state_d = DSETUP;
               end else begin
                  state_d = ERR;
                  err_evt = 1'b1;
               end
            end
         end
         DSETUP: state_d = DACCESS;
         DACCESS: begin
            if (sel_ready) begin
               latch_resp = 1'b1;
               state_d    = RESP;
            end else if (timeout_hit) begin
               latch_resp   = 1'b1;
               rdata_d      = '0;
               rerr_d       = 1'b1;
               err_evt      = 1'b1;
               err_evt_to   = 1'b1;
               err_evt_addr = paddr_o;
               state_d      = RESP;
            end
         end
         // If upstream abandoned the transfer, the response is dropped silently.
         RESP: begin
            if (!psel_i) begin
               state_d = IDLE;
            end else if (penable_i) begin
               pready_o  = 1'b1;
               pslverr_o = rerr_q;
               prdata_o  = rdata_q;
               state_d   = IDLE;
            end
         end
         ERR: begin
            if (!psel_i) begin
               state_d = IDLE;
            end else if (penable_i) begin
               pready_o  = 1'b1;
               pslverr_o = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign psel_o    = (state_q == DSETUP || state_q == DACCESS) ? sel_oh : '0;
   assign penable_o = (state_q == DACCESS);

   assign err_cnt_o     = err_cnt_q;
   assign err_addr_o    = err_addr_q;
   assign err_timeout_o = err_to_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         to_cnt_q <= '0;
         rdata_q  <= '0;
         rerr_q   <= 1'b0;
         paddr_o  <= '0;
         pwdata_o <= '0;
         pwrite_o <= 1'b0;
         pstrb_o  <= '0;
      end else begin
         state_q <= state_d;
         if (latch_req) begin
            paddr_o  <= paddr_i;
            pwdata_o <= pwdata_i;
            pwrite_o <= pwrite_i;
            pstrb_o  <= pstrb_i;
            idx_q    <= dec_idx;
         end
         if (state_q == DSETUP) begin
            to_cnt_q <= '0;
         end else if (state_q == DACCESS) begin
            to_cnt_q <= to_cnt_q + TW'(1);
         end
         if (latch_resp) begin
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
         end
      end
   end

   // A clear that coincides with a new error leaves that error as the only one logged.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_cnt_q  <= '0;
         err_addr_q <= '0;
         err_to_q   <= 1'b0;
      end else if (err_evt) begin
         err_addr_q <= err_evt_addr;
         err_to_q   <= err_evt_to;
         if (err_clr_i) begin
            err_cnt_q <= 8'd1;
         end else if (err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end
      end else if (err_clr_i) begin
         err_cnt_q  <= '0;
         err_addr_q <= '0;
         err_to_q   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_apb_soc_demux.sv
// Testbench for apb_soc_demux. Drives randomised and directed APB transfers and
// checks them against a transaction-level model of the address map and error log.
module tb_apb_soc_demux;

   localparam int unsigned NS  = 7;
   localparam int unsigned TMO = 256;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic [31:0]       paddr_i = '0;
   logic [31:0]       pwdata_i = '0;
   logic              pwrite_i = 1'b0;
   logic [3:0]        pstrb_i = '0;
   logic              psel_i = 1'b0;
   logic              penable_i = 1'b0;
   logic [31:0]       prdata_o;
   logic              pready_o;
   logic              pslverr_o;
   logic [31:0]       paddr_o;
   logic [31:0]       pwdata_o;
   logic              pwrite_o;
   logic [3:0]        pstrb_o;
   logic [NS-1:0]     psel_o;
   logic              penable_o;
   logic [NS*32-1:0]  prdata_i;
   logic [NS-1:0]     pready_i;
   logic [NS-1:0]     pslverr_i;
   logic              err_clr_i = 1'b0;
   logic [7:0]        err_cnt_o;
   logic [31:0]       err_addr_o;
   logic              err_timeout_o;

   int unsigned       checks = 0;
   int unsigned       errors = 0;

   // Slave farm: the selected slave answers after wait_cfg ACCESS cycles.
   logic [31:0]       slave_data [NS];
   int unsigned       wait_cfg = 0;
   logic              slverr_cfg = 1'b0;
   int unsigned       acc_cnt;

   // Reference address map and error log.
   int unsigned       m_start [NS] = '{32'h1A10_0000, 32'h1A10_1000, 32'h1A10_3000, 32'h1A10_4000,
                                       32'h1A10_5000, 32'h1A10_6000, 32'h1A20_0000};
   int unsigned       m_end   [NS] = '{32'h1A10_1000, 32'h1A10_2000, 32'h1A10_4000, 32'h1A10_5000,
                                       32'h1A10_6000, 32'h1A10_7000, 32'h1A22_2000};
   int unsigned       m_cnt  = 0;
   logic [31:0]       m_addr = '0;
   logic              m_to   = 1'b0;

   apb_soc_demux #(
      .NUM_SLAVES     (NS),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .paddr_i       (paddr_i),
      .pwdata_i      (pwdata_i),
      .pwrite_i      (pwrite_i),
      .pstrb_i       (pstrb_i),
      .psel_i        (psel_i),
      .penable_i     (penable_i),
      .prdata_o      (prdata_o),
      .pready_o      (pready_o),
      .pslverr_o     (pslverr_o),
      .paddr_o       (paddr_o),
      .pwdata_o      (pwdata_o),
      .pwrite_o      (pwrite_o),
      .pstrb_o       (pstrb_o),
      .psel_o        (psel_o),
      .penable_o     (penable_o),
      .prdata_i      (prdata_i),
      .pready_i      (pready_i),
      .pslverr_i     (pslverr_i),
      .err_clr_i     (err_clr_i),
      .err_cnt_o     (err_cnt_o),
      .err_addr_o    (err_addr_o),
      .err_timeout_o (err_timeout_o)
   );

   always #5 clk_i = ~clk_i;

   for (genvar g = 0; g < NS; g++) begin : g_slave
      assign prdata_i[g*32 +: 32] = slave_data[g];
   end

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                        acc_cnt <= 0;
      else if (psel_o != '0 && penable_o) acc_cnt <= acc_cnt + 1;
      else                                acc_cnt <= 0;
   end

   assign pready_i  = (penable_o && acc_cnt >= wait_cfg) ? psel_o : '0;
   assign pslverr_i = slverr_cfg ? psel_o : '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int m_decode(input logic [31:0] a);
      for (int k = 0; k < NS; k++)
         if (a >= m_start[k] && a < m_end[k]) return k;
      return -1;
   endfunction

   // One full upstream transfer, with its latency, response and error log predicted from the map.
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input int unsigned wt, input logic serr, input logic clr);
      int          k;
      bit          tmo, seen;
      int unsigned exp_lat, n;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic [NS-1:0] exp_sel;
      logic [3:0]  st;
      k       = m_decode(addr);
      tmo     = (k >= 0) && (wt >= TMO);
      exp_lat = (k < 0) ? 1 : (tmo ? 2 + TMO : 3 + wt);
      exp_rd  = (k < 0 || tmo) ? 32'h0 : slave_data[k];
      exp_err = (k < 0 || tmo) ? 1'b1 : serr;
      exp_sel = (k < 0) ? '0 : NS'(1 << k);
      st      = 4'($urandom);
      wait_cfg   = wt;
      slverr_cfg = serr;
      if (clr) begin
         m_cnt = 0; m_addr = '0; m_to = 1'b0;
      end
      if (k < 0 || tmo) begin
         if (m_cnt != 255) m_cnt++;
         m_addr = addr;
         m_to   = tmo;
      end
      @(negedge clk_i);
      paddr_i = addr; pwrite_i = wr; pwdata_i = wd; pstrb_i = st;
      psel_i = 1'b1; penable_i = 1'b0; err_clr_i = clr;
      #1;
      chk("setup_pready", 32'(pready_o), 32'd0);
      n = 0; seen = 0;
      while (!seen && n < 600) begin
         @(negedge clk_i);
         n++;
         if (n == 1) begin
            penable_i = 1'b1;
            err_clr_i = 1'b0;
         end
         #1;
         if (n == 1) begin
            chk("paddr_o", paddr_o, addr);
            chk("pwdata_o", pwdata_o, wd);
            chk("pwrite_o", 32'(pwrite_o), 32'(wr));
            chk("pstrb_o", 32'(pstrb_o), 32'(st));
            chk("dsetup_psel", 32'(psel_o), 32'(exp_sel));
            chk("dsetup_penable", 32'(penable_o), 32'd0);
         end
         if (n == 2 && k >= 0) begin
            chk("daccess_psel", 32'(psel_o), 32'(exp_sel));
            chk("daccess_penable", 32'(penable_o), 32'd1);
         end
         if (pready_o) seen = 1;
      end
      chk("latency", n, exp_lat);
      if (seen) begin
         chk("prdata_o", prdata_o, exp_rd);
         chk("pslverr_o", 32'(pslverr_o), 32'(exp_err));
         chk("resp_psel", 32'(psel_o), 32'd0);
         chk("err_cnt", 32'(err_cnt_o), m_cnt);
         chk("err_addr", err_addr_o, m_addr);
         chk("err_timeout", 32'(err_timeout_o), 32'(m_to));
      end
      @(negedge clk_i);
      psel_i = 1'b0; penable_i = 1'b0;
      #1;
      chk("idle_pready", 32'(pready_o), 32'd0);
      chk("idle_prdata", prdata_o, 32'd0);
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned k, r;
      k = $urandom_range(0, NS - 1);
      r = $urandom_range(0, 3);
      case (r)
         0: return m_start[k] + ($urandom_range(0, m_end[k] - m_start[k] - 1) & ~32'd3);
         1: return $urandom;
         2: return ($urandom_range(0, 1) == 1) ? m_end[k] : m_end[k] - 4;
         default: return 32'h1A10_2000 + ($urandom_range(0, 32'hFFF) & ~32'd3);
      endcase
   endfunction

   initial begin
      for (int k = 0; k < NS; k++) slave_data[k] = $urandom;

      // Reset state
      #12;
      chk("rst_psel", 32'(psel_o), 32'd0);
      chk("rst_penable", 32'(penable_o), 32'd0);
      chk("rst_pready", 32'(pready_o), 32'd0);
      chk("rst_paddr", paddr_o, 32'd0);
      chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);
      rst_ni = 1'b1;

      // Directed cases
      xfer(32'h1A10_5004, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
      slave_data[6] = 32'h1234_5678;
      xfer(32'h1A21_FFFC, 1'b0, 32'h0, 3, 1'b0, 1'b0);
      xfer(32'h1A10_2000, 1'b0, 32'h0, 0, 1'b0, 1'b0);
      xfer(32'h1A10_0010, 1'b0, 32'h0, 1000, 1'b0, 1'b0);
      xfer(32'h1A10_0020, 1'b0, 32'h0, TMO - 1, 1'b0, 1'b0);
      xfer(32'h1A10_3FFC, 1'b1, 32'h5A5A_A5A5, 1, 1'b1, 1'b0);

      // Randomised mixed traffic
      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < NS; k++) slave_data[k] = $urandom;
         xfer(rand_addr(), 1'($urandom), $urandom, $urandom_range(0, 4), 1'($urandom), 1'b0);
      end

      // Standalone clear
      @(negedge clk_i);
      err_clr_i = 1'b1;
      @(negedge clk_i);
      err_clr_i = 1'b0;
      m_cnt = 0; m_addr = '0; m_to = 1'b0;
      #1;
      chk("clr_cnt", 32'(err_cnt_o), 32'd0);
      chk("clr_addr", err_addr_o, 32'd0);
      chk("clr_to", 32'(err_timeout_o), 32'd0);

      // Saturation, then a clear that coincides with a new miss
      for (int i = 0; i < 300; i++)
         xfer(32'h1A30_0000 + ($urandom_range(0, 32'hFFFF) << 2), 1'b0, 32'h0, 0, 1'b0, 1'b0);
      chk("sat_cnt", 32'(err_cnt_o), 32'd255);
      xfer(32'h1A10_2ABC, 1'b0, 32'h0, 0, 1'b0, 1'b1);

      // Upstream drops psel mid-transfer, so the response must never surface
      wait_cfg = 2;
      @(negedge clk_i);
      paddr_i = 32'h1A10_3100; psel_i = 1'b1; penable_i = 1'b0;
      @(negedge clk_i);
      penable_i = 1'b1;
      @(negedge clk_i);
      psel_i = 1'b0; penable_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("abandon_pready", 32'(pready_o), 32'd0);
         @(negedge clk_i);
      end
      xfer(32'h1A10_3104, 1'b0, 32'h0, 0, 1'b0, 1'b0);

      // Asynchronous reset in DACCESS
      wait_cfg = 100;
      @(negedge clk_i);
      paddr_i = 32'h1A10_0000; psel_i = 1'b1; penable_i = 1'b0;
      @(negedge clk_i);
      penable_i = 1'b1;
      repeat (3) @(negedge clk_i);
      #1;
      chk("pre_rst_penable", 32'(penable_o), 32'd1);
      #1 rst_ni = 1'b0;
      #1;
      m_cnt = 0; m_addr = '0; m_to = 1'b0;
      chk("mid_rst_psel", 32'(psel_o), 32'd0);
      chk("mid_rst_penable", 32'(penable_o), 32'd0);
      chk("mid_rst_pready", 32'(pready_o), 32'd0);
      chk("mid_rst_err_cnt", 32'(err_cnt_o), 32'd0);
      #1 rst_ni = 1'b1;
      @(negedge clk_i);
      psel_i = 1'b0; penable_i = 1'b0;
      xfer(32'h1A10_0000, 1'b1, 32'hCAFE_F00D, 0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
